// File: rtl/goldschmidt_ctrl.sv
// rtl/goldschmidt_ctrl.sv - sequencing controller for the Goldschmidt divider datapath
//
// Purpose: this block time-multiplexes the single shared multiplier between N and D
// on every Goldschmidt iteration. It drives the K / N-D operand selects, strobes
// the external N, D and K working registers, and provides a start/busy/done
// handshake to the surrounding FPU logic.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-high reset
//   start     in   division request, accepted only while idle
//   busy      out  high in every state except IDLE
//   done      out  one-cycle pulse; the N register holds the quotient
//   opLoad    out  load N/D from operands (combinational, accept cycle only)
//   kSelect   out  0 = initial K from lookup, 1 = K = 2 - result
//   ndSelect  out  multiplier X operand: 0 = N, 1 = D
//   kLoad     out  capture the K generator output into the K register
//   nLoad     out  capture the multiplier result into the N register
//   dLoad     out  capture the multiplier result into the D register
//   iter      out  current iteration index, 0..ITER-1
module goldschmidt_ctrl #(
  parameter int ITER = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       opLoad,
  output logic       kSelect,
  output logic       ndSelect,
  output logic       kLoad,
  output logic       nLoad,
  output logic       dLoad,
  output logic [3:0] iter
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADK,
    S_MULN,
    S_MULD,
    S_WBD,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST_ITER = 4'(ITER - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] iter_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      iter  <= 4'd0;
    end else begin
      state <= state_nxt;
      iter  <= iter_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    iter_nxt  = iter;
    busy      = (state != S_IDLE);
    done      = 1'b0;
    opLoad    = 1'b0;
    kSelect   = 1'b0;
    ndSelect  = 1'b0;
    kLoad     = 1'b0;
    nLoad     = 1'b0;
    dLoad     = 1'b0;

    case (state)
      S_IDLE: begin
        // Gated by reset so an asserted reset forces every output low at once,
        // even while start is held high.
        if (start && !reset) begin
          opLoad    = 1'b1;
          iter_nxt  = 4'd0;
          state_nxt = S_LOADK;
        end
      end
      S_LOADK: begin
        kLoad     = 1'b1;
        state_nxt = S_MULN;
      end
      S_MULN: begin
        // Result register captures N*K at the end of this cycle.
        state_nxt = S_MULD;
      end
      S_MULD: begin
        // Result holds N*K now; the multiplier moves on to D*K.
        ndSelect  = 1'b1;
        nLoad     = 1'b1;
        state_nxt = S_WBD;
      end
      S_WBD: begin
        // Result holds D*K: write D back and, if another pass follows, derive
        // the next K = 2 - D from the same result in the same cycle.
        dLoad = 1'b1;
        if (iter == LAST_ITER) begin
          state_nxt = S_DONE;
        end else begin
          kSelect   = 1'b1;
          kLoad     = 1'b1;
          iter_nxt  = iter + 4'd1;
          state_nxt = S_MULN;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
